// File: rtl/filt_buf2_sched.sv
// Round-robin scheduler that lends frame buffer 2 to one in-place filter at a time.
// Optional watchdog abort for hung filters: define FILT_SCHED_WATCHDOG_EN.
module filt_buf2_sched #(
    parameter int NUM_FILT    = 4,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 12,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_FILT-1:0]        req_i,
    input  logic                       cam_busy_i,
    output logic [NUM_FILT-1:0]        filt_rst_o,
    output logic [NUM_FILT-1:0]        filt_en_o,
    input  logic [NUM_FILT-1:0]        filt_done_i,
    input  logic [NUM_FILT*ADDR_W-1:0] filt_rdaddr_i,
    input  logic [NUM_FILT*ADDR_W-1:0] filt_wraddr_i,
    input  logic [NUM_FILT*DATA_W-1:0] filt_dout_i,
    input  logic [NUM_FILT-1:0]        filt_we_i,
    output logic [ADDR_W-1:0]          rdaddr_buf2,
    output logic [ADDR_W-1:0]          wraddr_buf2,
    output logic [DATA_W-1:0]          dout_buf2,
    output logic                       we_buf2,
    output logic                       busy_o,
    output logic [NUM_FILT-1:0]        grant_o,
    output logic                       led_done,
    output logic                       err_o
);

    localparam int IDX_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_RST, S_EN, S_RUN, S_REL, S_ABORT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [NUM_FILT-1:0] r_grant;
    logic [IDX_W-1:0]    r_gidx;
    logic [IDX_W-1:0]    r_rr;
    logic [IDX_W-1:0]    w_rr_next;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_ok;
    logic                w_timeout;

`ifdef FILT_SCHED_WATCHDOG_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] r_timer;
    logic             r_err;

    // Timer is held at zero outside RUN, so it restarts on every RUN entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_timer <= (r_state == S_RUN) ? r_timer + 1'b1 : '0;
            if (r_state == S_RUN && w_next == S_ABORT)
                r_err <= 1'b1;
        end
    end

    assign w_timeout = (r_timer == TMR_W'(TIMEOUT_CYC - 1));
    assign err_o     = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // Scan downward from the farthest offset so the closest request above rr wins.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        int unsigned v_idx;
        v_idx      = 0;
        w_pick_ok  = 1'b0;
        w_pick_idx = '0;
        for (int i = NUM_FILT - 1; i >= 0; i--) begin
            v_idx = int'(r_rr) + i;
            if (v_idx >= NUM_FILT)
                v_idx = v_idx - NUM_FILT;
            if (req_i[v_idx]) begin
                w_pick_ok  = 1'b1;
                w_pick_idx = IDX_W'(v_idx);
            end
        end
    end

    assign w_rr_next = (r_gidx == IDX_W'(NUM_FILT - 1)) ? '0 : r_gidx + 1'b1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|req_i && !cam_busy_i) w_next = S_ARB;
            S_ARB:   w_next = (w_pick_ok && !cam_busy_i) ? S_RST : S_IDLE;
            S_RST:   w_next = S_EN;
            S_EN:    w_next = S_RUN;
            S_RUN: begin
                if (filt_done_i[r_gidx])
                    w_next = S_REL;
                else if (w_timeout)
                    w_next = S_ABORT;
            end
            S_REL:   w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_rr    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next;
            if (r_state == S_ARB && w_next == S_RST) begin
                r_grant <= NUM_FILT'(1) << w_pick_idx;
                r_gidx  <= w_pick_idx;
            end
            if (r_state == S_REL || r_state == S_ABORT) begin
                r_grant <= '0;
                r_rr    <= w_rr_next;
            end
        end
    end

    // Zero-latency routing keeps each filter's own address/data alignment intact.
    assign rdaddr_buf2 = (|r_grant) ? filt_rdaddr_i[int'(r_gidx)*ADDR_W +: ADDR_W] : '0;
    assign wraddr_buf2 = (|r_grant) ? filt_wraddr_i[int'(r_gidx)*ADDR_W +: ADDR_W] : '0;
    assign dout_buf2   = (|r_grant) ? filt_dout_i[int'(r_gidx)*DATA_W +: DATA_W]   : '0;
    assign we_buf2     = (r_state == S_RUN) ? filt_we_i[r_gidx] : 1'b0;

    assign filt_rst_o = (r_state == S_RST || r_state == S_ABORT) ? r_grant : '0;
    assign filt_en_o  = (r_state == S_EN) ? r_grant : '0;
    assign busy_o     = |r_grant;
    assign grant_o    = r_grant;
    assign led_done   = (r_state == S_REL);

endmodule
